cnt_sampler: RTL
================

Name: cnt_sampler

Overview:
- Downstream consumer of the 8-bit event counter (cnt, of outputs).
- Snapshots the count every WIN_CYC clocks and records whether overflow occurred during the window.
- Tags each snapshot with a wrapping sequence index and buffers it in a small FIFO.
- Drains the FIFO over a valid/ready interface to the reporting logic; records are dropped and counted when the FIFO is full.

Parameters:
- CNT_W, 8, width of the sampled count (matches the counter's cnt).
- WIN_CYC, 100, sampling window length in clock cycles (>=2).
- DEPTH, 4, FIFO depth in records (power of two, >=2).
- SEQ_W, 4, width of the wrapping sequence tag.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  synchronous, active-high reset.
- cnt_i  in  CNT_W  count value from the counter.
- of_i  in  1  overflow flag from the counter (may be a pulse or a level).
- en_i  in  1  sampling enable.
- rec_valid_o  out  1  head record available.
- rec_ready_i  in  1  consumer accepts the head record.
- rec_data_o  out  SEQ_W+1+CNT_W  head record, packed {seq, of_seen, cnt}.
- full_o  out  1  FIFO full.
- empty_o  out  1  FIFO empty.
- drop_cnt_o  out  8  dropped-sample count, saturates at 255.

Behaviour:
- Reset (sync, rst=1 at a rising edge): window timer=0, of_seen=0, seq=0, FIFO emptied (pointers 0), drop_cnt_o=0.
- Outputs after reset: rec_valid_o=0, empty_o=1, full_o=0, rec_data_o=0.
- Window timer: counts 0..WIN_CYC-1 while en_i=1 and wraps to 0. Tick = (en_i=1 and timer==WIN_CYC-1).
- en_i=0: timer forced to 0, of_seen cleared, no captures. FIFO reads continue normally.
- Sticky overflow: of_seen |= of_i every enabled cycle.
- On tick: record = {seq, of_seen|of_i, cnt_i}, using cnt_i of the tick cycle; of_i in the tick cycle is included in this record.
- After a tick: of_seen cleared and seq incremented (mod 2^SEQ_W). seq increments even when the record is dropped, so the consumer sees gaps.
- Push on tick:
  - FIFO not full: record written.
  - FIFO full with no pop that cycle: record dropped, drop_cnt_o incremented, saturating at 255.
  - FIFO full with a pop that cycle: push accepted, occupancy unchanged, no drop.
- Pop: occurs when rec_valid_o && rec_ready_i. rec_ready_i while empty has no effect.
- Push and pop in the same cycle on a non-full FIFO: both performed, occupancy unchanged.
- Latency: a record captured at tick edge N is visible on rec_data_o with rec_valid_o=1 from edge N+1 when the FIFO was empty (first-word fall-through from the register array, no extra read cycle).
- rec_data_o stable while rec_valid_o=1 and rec_ready_i=0.
- rec_valid_o = !empty_o. Status flags are derived from an occupancy counter of width clog2(DEPTH)+1.
- Reset mid-window or mid-drain: discards the partial window and all buffered records. The first post-reset record has seq=0.

Decomposition:
- Shared package cnt_pkg:
  - CNT_W default constant.
  - Record field offsets/widths (SEQ_W, OF bit position).
  - Packed record typedef rec_t.
  - Drop counter width constant DROP_W=8.
- One natural sub-module, sync_fifo: parameterised width/depth, sync active-high reset, full/empty/count, fall-through output.
- cnt_sampler holds the window timer, sticky overflow, sequence tag, drop logic and the FIFO instance.

Test Plan (WIN_CYC=10, DEPTH=4, SEQ_W=4, rec_ready_i=1 unless stated):
- Basic capture: rst 2 cycles, en_i=1, cnt_i ramps +1/cycle from 0 -> first record {seq=0, of=0, cnt=9} valid on the cycle after the 10th enabled edge; next record {1, 0, 19}.
- Overflow sticky: of_i pulsed 1 cycle at timer=3 of window 2 -> that record has of=1, the next has of=0; of_i pulsed exactly on the tick cycle -> of=1 in the same record.
- Backpressure/full: rec_ready_i=0 for 60 cycles -> 4 records stored, full_o=1, 2 ticks dropped, drop_cnt_o=2; release ready -> records seq 0..3 drain in order, next stored seq=6.
- Simultaneous push/pop at full: hold full, assert rec_ready_i exactly on a tick cycle -> head seq popped, new record accepted, full_o stays 1, drop_cnt_o unchanged.
- Enable/wrap: en_i dropped at timer=5 for 3 cycles then restored -> next record occurs 10 cycles after re-enable; run 17 windows -> seq wraps 15->0.
- Reset mid-operation: 3 records buffered, rst pulsed 1 cycle -> rec_valid_o=0, drop_cnt_o=0 next cycle; first new record seq=0 after 10 enabled cycles.

Source files
------------

// File: rtl/cnt_pkg.sv
// Shared constants and record layout for the count sampler.
// Record is packed {seq, of_seen, cnt}, MSB first.
package cnt_pkg;
  localparam int CNT_W   = 8;
  localparam int SEQ_W   = 4;
  localparam int OF_POS  = CNT_W;
  localparam int SEQ_LSB = CNT_W + 1;
  localparam int REC_W   = SEQ_W + 1 + CNT_W;
  localparam int DROP_W  = 8;

  typedef struct packed {
    logic [SEQ_W-1:0] seq;
    logic             of_seen;
    logic [CNT_W-1:0] cnt;
  } rec_t;
endpackage

// File: rtl/sync_fifo.sv
// Synchronous FIFO with occupancy counter and fall-through head.
// A push into a full FIFO is accepted only alongside a pop.
module sync_fifo #(
  parameter int W     = 8,
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     i_push,
  input  logic                     i_pop,
  input  logic [W-1:0]             i_data,
  output logic [W-1:0]             o_data,
  output logic                     o_full,
  output logic                     o_empty,
  output logic [$clog2(DEPTH):0]   o_count
);
  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_N = (AW+1)'(DEPTH);

  logic [W-1:0]  r_mem [DEPTH];
  logic [AW-1:0] r_wptr;
  logic [AW-1:0] r_rptr;
  logic [AW:0]   r_count;
  logic          w_pop;
  logic          w_push;

  assign o_full  = (r_count == FULL_N);
  assign o_empty = (r_count == '0);
  assign o_count = r_count;
  assign w_pop   = i_pop & ~o_empty;
  assign w_push  = i_push & (~o_full | w_pop);
  assign o_data  = o_empty ? '0 : r_mem[r_rptr];

  always_ff @(posedge clk) begin
    if (rst) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
    end else begin
      if (w_push) r_wptr <= r_wptr + 1'b1;
      if (w_pop)  r_rptr <= r_rptr + 1'b1;
      unique case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

  // Storage needs no reset; the head is masked while empty.
  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wptr] <= i_data;
  end
endmodule

// File: rtl/cnt_sampler.sv
// Windowed snapshot of the event counter with sticky overflow,
// sequence tag, drop counting and a valid/ready record FIFO.
module cnt_sampler #(
  parameter int CNT_W   = cnt_pkg::CNT_W,
  parameter int WIN_CYC = 100,
  parameter int DEPTH   = 4,
  parameter int SEQ_W   = cnt_pkg::SEQ_W
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [CNT_W-1:0]         cnt_i,
  input  logic                     of_i,
  input  logic                     en_i,
  output logic                     rec_valid_o,
  input  logic                     rec_ready_i,
  output logic [SEQ_W+CNT_W:0]     rec_data_o,
  output logic                     full_o,
  output logic                     empty_o,
  output logic [7:0]               drop_cnt_o
);
  import cnt_pkg::*;

  localparam int TW = $clog2(WIN_CYC);
  localparam int RW = SEQ_W + 1 + CNT_W;
  localparam int CW = $clog2(DEPTH) + 1;
  localparam logic [TW-1:0] T_LAST = TW'(WIN_CYC - 1);
  localparam logic [CW-1:0] N_FULL = CW'(DEPTH);
  localparam logic [DROP_W-1:0] D_MAX = '1;

  logic [TW-1:0]     r_timer;
  logic              r_of_seen;
  logic [SEQ_W-1:0]  r_seq;
  logic [DROP_W-1:0] r_drop;
  logic              w_tick;
  logic              w_pop;
  logic              w_drop;
  logic              w_full;
  logic              w_empty;
  logic [CW-1:0]     w_count;
  logic [RW-1:0]     w_rec;

  assign w_tick = en_i & (r_timer == T_LAST);
  assign w_pop  = rec_valid_o & rec_ready_i;
  assign w_drop = w_tick & w_full & ~w_pop;
  assign w_rec  = {r_seq, r_of_seen | of_i, cnt_i};

  always_ff @(posedge clk) begin
    if (rst) begin
      r_timer   <= '0;
      r_of_seen <= 1'b0;
      r_seq     <= '0;
    end else if (!en_i) begin
      r_timer   <= '0;
      r_of_seen <= 1'b0;
    end else if (w_tick) begin
      r_timer   <= '0;
      r_of_seen <= 1'b0;
      r_seq     <= r_seq + 1'b1;
    end else begin
      r_timer   <= r_timer + 1'b1;
      r_of_seen <= r_of_seen | of_i;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_drop <= '0;
    end else if (w_drop && r_drop != D_MAX) begin
      r_drop <= r_drop + 1'b1;
    end
  end

  sync_fifo #(
    .W     (RW),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .i_push  (w_tick),
    .i_pop   (rec_ready_i),
    .i_data  (w_rec),
    .o_data  (rec_data_o),
    .o_full  (w_full),
    .o_empty (w_empty),
    .o_count (w_count)
  );

  assign rec_valid_o = ~w_empty;
  assign full_o      = (w_count == N_FULL);
  assign empty_o     = (w_count == '0);
  assign drop_cnt_o  = r_drop;
endmodule
